r2_prod_round: RTL and testbench

R2_PROD_ROUND -- requirements
Module: r2_prod_round

---
 rtl/r2_prod_round.sv | 180 ++++++++++++++++++
 tb/tb_r2_prod_round.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2_prod_round.sv
// r2_prod_round: normalize, round and pack a 24x24 radix-2 mantissa product into single precision.
// Latency: 2 cycles from input handshake to o_valid (S1 normalize, S2 round/pack), one result per cycle.
// Backpressure: elastic; a stage advances when empty or when the stage after it advances; o_ready is combinational.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_valid/o_ready               input handshake for i_product, i_exp_a, i_exp_b, i_sign
//   o_valid/i_ready               output handshake for o_sign, o_exp, o_mant and the status flags
//   o_overflow/underflow/inexact  status flags, meaningful only while o_valid=1
// Configuration: define R2_PROD_ROUND_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module r2_prod_round #(
  parameter int BIAS = 127
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [47:0] i_product,
  input  logic [7:0]  i_exp_a,
  input  logic [7:0]  i_exp_b,
  input  logic        i_sign,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [22:0] o_mant,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_inexact
);

  localparam logic [9:0] BIAS_W = 10'(BIAS);

  // Handshake
  logic adv1, adv2;

  // Stage 1 (normalized product)
  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q,  s1_sign_d;
  logic        s1_zero_q,  s1_zero_d;
  logic [22:0] s1_mant_q,  s1_mant_d;
  logic        s1_g_q,     s1_g_d;
  logic        s1_s_q,     s1_s_d;
  logic [9:0]  s1_exp_q,   s1_exp_d;   // two's complement, never wraps for 8-bit inputs

  // Stage 2 (packed result, drives the outputs directly)
  logic        s2_valid_q, s2_valid_d;
  logic        s2_sign_q,  s2_sign_d;
  logic [7:0]  s2_exp_q,   s2_exp_d;
  logic [22:0] s2_mant_q,  s2_mant_d;
  logic        s2_ovf_q,   s2_ovf_d;
  logic        s2_unf_q,   s2_unf_d;
  logic        s2_inx_q,   s2_inx_d;

  // Rounding datapath
  logic        round_inc;
  logic [23:0] mant_sum;
  logic [9:0]  exp_r;

  assign adv2    = ~s2_valid_q | i_ready;
  assign adv1    = ~s1_valid_q | adv2;
  assign o_ready = adv1;

  // S1: pick the leading-one position (bit 47 or 46) and split off guard and sticky.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_mant_d  = s1_mant_q;
    s1_g_d     = s1_g_q;
    s1_s_d     = s1_s_q;
    s1_exp_d   = s1_exp_q;
    if (adv1) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_sign_d = i_sign;
        s1_zero_d = (i_product == 48'd0);
        s1_exp_d  = {2'b00, i_exp_a} + {2'b00, i_exp_b} - BIAS_W + {9'd0, i_product[47]};
        if (i_product[47]) begin
          s1_mant_d = i_product[46:24];
          s1_g_d    = i_product[23];
          s1_s_d    = |i_product[22:0];
        end else begin
          s1_mant_d = i_product[45:23];
          s1_g_d    = i_product[22];
          s1_s_d    = |i_product[21:0];
        end
      end
    end
  end

  // S2: round, absorb a mantissa carry into the exponent, then clamp to the representable range.
  always_comb begin
`ifdef R2_PROD_ROUND_RNE_EN
    round_inc = s1_g_q & (s1_s_q | s1_mant_q[0]);
`else
    round_inc = 1'b0;
`endif
    // An all-ones mantissa rolling over leaves mant_sum[22:0]=0 and carries into the exponent.
    mant_sum = {1'b0, s1_mant_q} + {23'd0, round_inc};
    exp_r    = s1_exp_q + {9'd0, mant_sum[23]};

    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_mant_d  = s2_mant_q;
    s2_ovf_d   = s2_ovf_q;
    s2_unf_d   = s2_unf_q;
    s2_inx_d   = s2_inx_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_exp_d  = exp_r[7:0];
        s2_mant_d = mant_sum[22:0];
        s2_ovf_d  = 1'b0;
        s2_unf_d  = 1'b0;
        s2_inx_d  = s1_g_q | s1_s_q;
        if (s1_zero_q) begin
          s2_exp_d  = 8'd0;
          s2_mant_d = 23'd0;
          s2_inx_d  = 1'b0;
        end else if ($signed(exp_r) >= 10'sd255) begin
          s2_exp_d  = 8'd255;
          s2_mant_d = 23'd0;
          s2_ovf_d  = 1'b1;
        end else if ($signed(exp_r) <= 10'sd0) begin
          // Flush to zero: the discarded value is always lost, so the result is inexact.
          s2_exp_d  = 8'd0;
          s2_mant_d = 23'd0;
          s2_unf_d  = 1'b1;
          s2_inx_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mant_q  <= 23'd0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_exp_q   <= 10'd0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= 8'd0;
      s2_mant_q  <= 23'd0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_inx_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_mant_q  <= s1_mant_d;
      s1_g_q     <= s1_g_d;
      s1_s_q     <= s1_s_d;
      s1_exp_q   <= s1_exp_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_mant_q  <= s2_mant_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_unf_q   <= s2_unf_d;
      s2_inx_q   <= s2_inx_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_sign      = s2_sign_q;
  assign o_exp       = s2_exp_q;
  assign o_mant      = s2_mant_q;
  assign o_overflow  = s2_ovf_q;
  assign o_underflow = s2_unf_q;
  assign o_inexact   = s2_inx_q;

endmodule

// File: tb/tb_r2_prod_round.sv
// tb_r2_prod_round: scoreboard bench for r2_prod_round.
// Result vector layout: {sign, exp[7:0], mant[22:0], overflow, underflow, inexact}.
module tb_r2_prod_round;

  localparam int BIAS = 127;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [47:0] i_product = '0;
  logic [7:0]  i_exp_a = '0;
  logic [7:0]  i_exp_b = '0;
  logic        i_sign = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [22:0] o_mant;
  logic        o_overflow, o_underflow, o_inexact;

  logic [34:0] got;
  logic [34:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int cyc     = 0;

  r2_prod_round #(.BIAS(BIAS)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_product(i_product), .i_exp_a(i_exp_a), .i_exp_b(i_exp_b), .i_sign(i_sign),
    .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .o_inexact(o_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign got = {o_sign, o_exp, o_mant, o_overflow, o_underflow, o_inexact};

  // Reference model, written in integer arithmetic on the full product.
  function automatic logic [34:0] model(input logic [47:0] p, input logic [7:0] ea,
                                        input logic [7:0] eb, input logic sg);
    int     e;
    longint m;
    logic   g, s, ovf, unf, inx;
    if (p == 48'd0) return {sg, 8'd0, 23'd0, 3'b000};
    e = int'(ea) + int'(eb) - BIAS;
    if (p[47]) begin
      e++;
      m = longint'(p >> 24);
      g = p[23];
      s = (p[22:0] != 23'd0);
    end else begin
      m = longint'(p >> 23);
      g = p[22];
      s = (p[21:0] != 22'd0);
    end
`ifdef R2_PROD_ROUND_RNE_EN
    if (g && (s || m[0])) m++;
    if (m >= 64'h100_0000) begin
      m = m >> 1;
      e++;
    end
`endif
    inx = g | s;
    ovf = 1'b0;
    unf = 1'b0;
    if (e >= 255) begin
      e = 255; m = 0; ovf = 1'b1;
    end else if (e <= 0) begin
      e = 0; m = 0; unf = 1'b1; inx = 1'b1;
    end
    return {sg, e[7:0], m[22:0], ovf, unf, inx};
  endfunction

  // Output monitor: every output handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      n_out++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected got=%h required=none", got);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL out_data got=%h required=%h", got, e);
        end
      end
    end
  end

  // Drive one input; called at posedge+1, returns at posedge+1 after the accepting edge.
  task automatic send(input logic [47:0] p, input logic [7:0] ea, input logic [7:0] eb,
                      input logic sg, input logic [34:0] e);
    int w = 0;
    i_valid = 1'b1; i_product = p; i_exp_a = ea; i_exp_b = eb; i_sign = sg;
    @(negedge clk);
    while (!o_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout o_ready=%b required=1", o_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_m(input logic [47:0] p, input logic [7:0] ea, input logic [7:0] eb,
                        input logic sg);
    send(p, ea, eb, sg, model(p, ea, eb, sg));
  endtask

  task automatic rand_item(input int k, output logic [47:0] p, output logic [7:0] ea,
                           output logic [7:0] eb, output logic sg);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    p = r[47:0];
    if (!p[47]) p[46] = 1'b1;
    if (k % 7 == 3) p = 48'd0;
    ea = 8'($urandom_range(0, 255));
    eb = 8'($urandom_range(0, 255));
    sg = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int w = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_tests++;
    if ({o_valid, o_ready, got} !== {1'b0, 1'b1, 35'd0}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b r=%b out=%h required v=0 r=1 out=0", o_valid, o_ready, got);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    // First input presented right after release must be taken on the next rising edge.
    i_valid = 1'b1; i_product = 48'h4000_0000_0000; i_exp_a = 8'd127; i_exp_b = 8'd127; i_sign = 1'b1;
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_accept o_ready=%b required=1", o_ready);
    end
    exp_q.push_back({1'b1, 8'd127, 23'd0, 3'b000});
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_latency();
    i_ready = 1'b1;
    i_valid = 1'b1; i_product = 48'h9000_0000_0000; i_exp_a = 8'd127; i_exp_b = 8'd127; i_sign = 1'b0;
    @(negedge clk);
    if (o_ready) exp_q.push_back({1'b0, 8'd128, 23'h100000, 3'b000});
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early o_valid=%b required=0", o_valid);
    end
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_2cyc o_valid=%b required=1", o_valid);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_scenarios();
    i_ready = 1'b1;
    send(48'h4000_0000_0000, 8'd127, 8'd127, 1'b0, {1'b0, 8'd127, 23'd0, 3'b000});
    send(48'h9000_0000_0000, 8'd127, 8'd127, 1'b0, {1'b0, 8'd128, 23'h100000, 3'b000});
    send(48'h4000_0040_0000, 8'd127, 8'd127, 1'b0, {1'b0, 8'd127, 23'd0, 3'b001});
`ifdef R2_PROD_ROUND_RNE_EN
    send(48'h4000_00C0_0000, 8'd127, 8'd127, 1'b0, {1'b0, 8'd127, 23'd2, 3'b001});
    send(48'h7FFF_FFC0_0000, 8'd127, 8'd127, 1'b0, {1'b0, 8'd128, 23'd0, 3'b001});
`else
    send(48'h4000_00C0_0000, 8'd127, 8'd127, 1'b0, {1'b0, 8'd127, 23'd1, 3'b001});
    send(48'h7FFF_FFC0_0000, 8'd127, 8'd127, 1'b0, {1'b0, 8'd127, 23'h7FFFFF, 3'b001});
`endif
    send(48'h4000_0000_0000, 8'd254, 8'd254, 1'b1, {1'b1, 8'd255, 23'd0, 3'b100});
    send(48'h4000_0000_0000, 8'd1,   8'd1,   1'b0, {1'b0, 8'd0,   23'd0, 3'b011});
    send(48'h0000_0000_0000, 8'd200, 8'd90,  1'b1, {1'b1, 8'd0,   23'd0, 3'b000});
    // Exponent edges: exactly 254 stays normal, exactly 1 stays normal.
    send(48'h4000_0000_0000, 8'd254, 8'd127, 1'b0, {1'b0, 8'd254, 23'd0, 3'b000});
    send(48'h4000_0000_0000, 8'd1,   8'd127, 1'b0, {1'b0, 8'd1,   23'd0, 3'b000});
    drain();
  endtask

  task automatic test_backpressure();
    logic [47:0] p[4];
    logic [7:0]  ea[4], eb[4];
    logic        sg[4];
    logic [34:0] hold_v;
    int sent = 0;
    int out0;
    for (int k = 0; k < 4; k++) rand_item(k + 1, p[k], ea[k], eb[k], sg[k]);
    out0 = n_out;
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1; i_product = p[sent]; i_exp_a = ea[sent]; i_exp_b = eb[sent]; i_sign = sg[sent];
      @(negedge clk);
      if (c == 2) begin
        hold_v = got;
        n_tests++;
        if ({o_valid, o_ready} !== 2'b10) begin
          n_fail++;
          $display("FAIL bp_stall got v=%b r=%b required v=1 r=0", o_valid, o_ready);
        end
      end
      if (o_ready) begin
        exp_q.push_back(model(p[sent], ea[sent], eb[sent], sg[sent]));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    n_tests++;
    if (sent != 2) begin
      n_fail++;
      $display("FAIL bp_accepted got=%0d required=2", sent);
    end
    i_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({o_valid, got} !== {1'b1, hold_v}) begin
      n_fail++;
      $display("FAIL bp_hold got v=%b out=%h required v=1 out=%h", o_valid, got, hold_v);
    end
    @(posedge clk);
    #1;
    for (int k = sent; k < 4; k++) send_m(p[k], ea[k], eb[k], sg[k]);
    drain();
    n_tests++;
    if (n_out - out0 != 4) begin
      n_fail++;
      $display("FAIL bp_count got=%0d required=4", n_out - out0);
    end
  endtask

  task automatic test_reset_mid();
    int out0;
    i_ready = 1'b0;
    send_m(48'h9000_0000_0000, 8'd130, 8'd120, 1'b1);
    send_m(48'h4000_00C0_0000, 8'd100, 8'd100, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_valid, o_ready, got} !== {1'b0, 1'b1, 35'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_state got v=%b r=%b out=%h required v=0 r=1 out=0", o_valid, o_ready, got);
    end
    exp_q.delete();
    out0 = n_out;
    @(negedge clk);
    rst = 1'b0;
    i_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (n_out != out0) begin
      n_fail++;
      $display("FAIL rst_mid_flush outputs=%0d required=0", n_out - out0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [47:0] p;
    logic [7:0]  ea, eb;
    logic        sg;
    int c0;
    i_ready = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 30; k++) begin
      rand_item(k, p, ea, eb, sg);
      send_m(p, ea, eb, sg);
    end
    n_tests++;
    if (cyc - c0 != 30) begin
      n_fail++;
      $display("FAIL b2b_throughput cycles=%0d required=30", cyc - c0);
    end
    drain();
  endtask

  task automatic test_random_stall();
    logic [47:0] p;
    logic [7:0]  ea, eb;
    logic        sg;
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          rand_item(k + 5, p, ea, eb, sg);
          send_m(p, ea, eb, sg);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_scenarios();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
